// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects operand A, operand B and opcode bytes from the UART
// receiver, drives the ALU, and returns the one-byte result to the UART
// transmitter.
// Optional build macro ALU_CTRL_TIMEOUT_EN: adds an inter-byte timeout that
// discards a partial frame after TIMEOUT idle cycles in S_B or S_OP.
module alu_uart_ctrl #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_REG  = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_REG-1:0]  o_alu_a,
    output logic [NB_REG-1:0]  o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_REG-1:0]  i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_busy,
    output logic               o_busy,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SEND = 3'd4,
        S_TXW  = 3'd5,
        S_TXD  = 3'd6
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [NB_REG-1:0]    alu_a_next;
    logic [NB_REG-1:0]    alu_b_next;
    logic [NB_OP-1:0]     alu_op_next;
    logic [NB_DATA-1:0]   tx_data_next;
    logic                 tx_start_next;
    logic                 busy_next;
    logic                 overrun_next;

`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     to_cnt;
    logic [CNT_W-1:0]     to_cnt_next;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= S_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            state      <= state_next;
            o_alu_a    <= alu_a_next;
            o_alu_b    <= alu_b_next;
            o_alu_op   <= alu_op_next;
            o_tx_data  <= tx_data_next;
            o_tx_start <= tx_start_next;
            o_busy     <= busy_next;
            o_overrun  <= overrun_next;
`ifdef ALU_CTRL_TIMEOUT_EN
            to_cnt     <= to_cnt_next;
`endif
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_next    = state;
        alu_a_next    = o_alu_a;
        alu_b_next    = o_alu_b;
        alu_op_next   = o_alu_op;
        tx_data_next  = o_tx_data;
        tx_start_next = 1'b0;
        overrun_next  = o_overrun;
`ifdef ALU_CTRL_TIMEOUT_EN
        to_cnt_next   = '0;
`endif
        case (state)
            S_A: begin
                if (i_rx_valid) begin
                    alu_a_next = NB_REG'(i_rx_data);
                    state_next = S_B;
                end
            end
            S_B: begin
                if (i_rx_valid) begin
                    alu_b_next = NB_REG'(i_rx_data);
                    state_next = S_OP;
                end
`ifdef ALU_CTRL_TIMEOUT_EN
                else if (to_cnt == CNT_W'(TIMEOUT)) begin
                    state_next = S_A;
                end else begin
                    to_cnt_next = to_cnt + CNT_W'(1);
                end
`endif
            end
            S_OP: begin
                if (i_rx_valid) begin
                    alu_op_next = i_rx_data[NB_OP-1:0];
                    state_next  = S_EXEC;
                end
`ifdef ALU_CTRL_TIMEOUT_EN
                else if (to_cnt == CNT_W'(TIMEOUT)) begin
                    state_next = S_A;
                end else begin
                    to_cnt_next = to_cnt + CNT_W'(1);
                end
`endif
            end
            S_EXEC: begin
                if (i_rx_valid) overrun_next = 1'b1;
                tx_data_next = NB_DATA'(i_alu_result);
                state_next   = S_SEND;
            end
            S_SEND: begin
                if (i_rx_valid) overrun_next = 1'b1;
                if (!i_tx_busy) begin
                    tx_start_next = 1'b1;
                    state_next    = S_TXW;
                end
            end
            S_TXW: begin
                if (i_rx_valid) overrun_next = 1'b1;
                if (i_tx_busy) state_next = S_TXD;
            end
            S_TXD: begin
                if (i_rx_valid) overrun_next = 1'b1;
                if (!i_tx_busy) state_next = S_A;
            end
            default: begin
                state_next = S_A;
            end
        endcase
        // o_busy is registered from the next state so it always equals (state != S_A)
        busy_next = (state_next != S_A);
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed self-checking bench for alu_uart_ctrl with a small ALU model and a
// UART transmitter model that stays busy for 8 cycles after each start pulse.
module tb_alu_uart_ctrl;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_REG  = 8;
    localparam int unsigned NB_OP   = 6;
`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 20;
`else
    localparam int unsigned TIMEOUT = 100000;
`endif

    logic               clk;
    logic               rst_n;
    logic [NB_DATA-1:0] rx_data;
    logic               rx_valid;
    logic [NB_REG-1:0]  alu_a;
    logic [NB_REG-1:0]  alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_REG-1:0]  alu_result;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic               busy;
    logic               overrun;

    logic               ext_busy;
    int unsigned        tx_cnt;
    int unsigned        start_cnt;
    int unsigned        checks;
    int unsigned        errors;

    alu_uart_ctrl #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .NB_OP   (NB_OP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .i_rst        (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_busy    (tx_busy),
        .o_busy       (busy),
        .o_overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h26:   alu_result = alu_a ^ alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    // Transmitter stand-in: busy the cycle after start, for 8 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_cnt <= 0;
        else if (tx_start) tx_cnt <= 8;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0) || ext_busy;

    // Count every clock edge that sees a start pulse
    always @(posedge clk) begin
        if (tx_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && tx_cnt == 0) break;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Full frame with idle transmitter: registers, 2-cycle latency, result, one pulse
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp_res);
        int unsigned s0;
        s0 = start_cnt;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check({tag, "_a"}, 32'(alu_a), 32'(a));
        check({tag, "_b"}, 32'(alu_b), 32'(b));
        check({tag, "_op"}, 32'(alu_op), 32'(op[5:0]));
        check({tag, "_start_early"}, 32'(tx_start), 32'd0);
        @(negedge clk);
        check({tag, "_start_lat1"}, 32'(tx_start), 32'd0);
        @(negedge clk);
        check({tag, "_start_lat2"}, 32'(tx_start), 32'd1);
        check({tag, "_txdata"}, 32'(tx_data), 32'(exp_res));
        wait_idle({tag, "_idle"});
        check({tag, "_pulses"}, start_cnt - s0, 32'd1);
        check({tag, "_txdata_hold"}, 32'(tx_data), 32'(exp_res));
    endtask

    initial begin
        int unsigned s0;
        checks    = 0;
        errors    = 0;
        start_cnt = 0;
        ext_busy  = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rst_n     = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_a", 32'(alu_a), 32'd0);
        check("rst_b", 32'(alu_b), 32'd0);
        check("rst_op", 32'(alu_op), 32'd0);
        check("rst_txdata", 32'(tx_data), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 5 + 3 = 8
        run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
        check("add_overrun", 32'(overrun), 32'd0);

        // AND with transmitter busy for 10 cycles after the opcode
        s0 = start_cnt;
        send_byte(8'hF0);
        send_byte(8'h0F);
        ext_busy = 1'b1;
        send_byte(8'h24);
        repeat (9) @(negedge clk);
        check("and_held_busy", start_cnt - s0, 32'd0);
        check("and_held_state", 32'(busy), 32'd1);
        ext_busy = 1'b0;
        @(negedge clk);
        check("and_start", 32'(tx_start), 32'd1);
        check("and_txdata", 32'(tx_data), 32'h00);

        // Extra byte while in S_TXW is dropped and flags overrun
        send_byte(8'h55);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_a_kept", 32'(alu_a), 32'hF0);
        wait_idle("and_idle");
        check("and_pulses", start_cnt - s0, 32'd1);

        // SUB still works; overrun sticky
        run_frame("sub", 8'h02, 8'h01, 8'h22, 8'h01);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-frame
        send_byte(8'hAA);
        check("mid_a", 32'(alu_a), 32'hAA);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a", 32'(alu_a), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("or", 8'h07, 8'h02, 8'h25, 8'h07);

        // Back-to-back frames; upper opcode bits ignored (0xE6 -> XOR)
        run_frame("b2b1", 8'h10, 8'h20, 8'h20, 8'h30);
        run_frame("b2b2", 8'h09, 8'h04, 8'hE6, 8'h0D);
        check("b2b_overrun", 32'(overrun), 32'd0);

        // Subtraction wrap-around
        run_frame("wrap", 8'h00, 8'h01, 8'h22, 8'hFF);

`ifdef ALU_CTRL_TIMEOUT_EN
        // Partial frame abandoned after the inter-byte timeout
        send_byte(8'h11);
        check("to_busy_before", 32'(busy), 32'd1);
        repeat (25) @(negedge clk);
        check("to_busy_after", 32'(busy), 32'd0);
        check("to_a_kept", 32'(alu_a), 32'h11);
        run_frame("to_next", 8'h03, 8'h04, 8'h20, 8'h07);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
- Sequences the ALU from a UART byte stream instead of board switches and buttons.
- Collects three received bytes in order: operand A, operand B, opcode.
- Then drives the ALU, captures the result and hands it to the UART transmitter as one byte.
- Sits between uart_rx/uart_tx and alu in the TP2 top level.

Parameters:
- NB_DATA, 8, UART byte width; must equal NB_REG.
- NB_REG, 8, ALU operand/result width.
- NB_OP, 6, ALU opcode width; opcode is taken from the low NB_OP bits of the third byte.
- TIMEOUT, 100000, idle clock cycles allowed between bytes of one frame (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_valid=1.
- i_rx_valid  in  1  one-cycle strobe per received byte.
- o_alu_a  out  NB_REG  operand A to the ALU.
- o_alu_b  out  NB_REG  operand B to the ALU.
- o_alu_op  out  NB_OP  opcode to the ALU.
- i_alu_result  in  NB_REG  combinational ALU output.
- o_tx_data  out  NB_DATA  byte to transmit; held stable from o_tx_start until return to S_A.
- o_tx_start  out  1  one-cycle pulse requesting transmission.
- i_tx_busy  in  1  transmitter busy; rises the cycle after o_tx_start and stays high for the frame.
- o_busy  out  1  high in every state except S_A.
- o_overrun  out  1  sticky flag: a byte arrived while not accepting.

Behaviour:
- Reset (i_rst=0, async): state S_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data all zero; o_tx_start=0; o_overrun=0.
- States:
  - S_A: on i_rx_valid, register byte into o_alu_a -> S_B.
  - S_B: on i_rx_valid, register into o_alu_b -> S_OP.
  - S_OP: on i_rx_valid, register i_rx_data[NB_OP-1:0] into o_alu_op -> S_EXEC.
  - S_EXEC: one settle cycle; capture i_alu_result into o_tx_data -> S_SEND.
  - S_SEND: if i_tx_busy=0, assert o_tx_start for exactly one cycle -> S_TXW; otherwise stay.
  - S_TXW: wait for i_tx_busy=1 -> S_TXD.
  - S_TXD: wait for i_tx_busy=0 -> S_A.
- Latency: o_tx_start is high exactly 2 cycles after the edge sampling the opcode byte, when the transmitter is idle.
- Operand and opcode registers hold their values after a frame until overwritten by the next frame. The ALU output stays valid for observation.
- i_rx_valid in S_EXEC, S_SEND, S_TXW or S_TXD: byte dropped, o_overrun set to 1. o_overrun clears only on reset.
- i_rx_valid is ignored whenever it is 0; no partial-byte handling.
- Reset asserted mid-frame or mid-transmit: immediate return to S_A with reset values. Any pending o_tx_start is suppressed.
- o_busy is purely a decode of state (0 only in S_A).

Optional Feature:
- Macro ALU_CTRL_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) is active in S_B and S_OP.
  - It resets to 0 on every accepted byte and on entry to S_A.
  - If it reaches TIMEOUT with no i_rx_valid, the state returns to S_A on that cycle; the partial frame is discarded. Operand registers keep their last written values.
  - i_rx_valid on the same cycle as the timeout wins: the byte is accepted and the counter clears.
- Not defined: no counter is present; S_B and S_OP wait indefinitely.

Test Plan:
- Bytes 0x05, 0x03, 0x20 (ADD), transmitter idle -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20. o_tx_start pulses once, 2 cycles after the third byte, with o_tx_data=0x08. o_busy back to 0 after the i_tx_busy frame completes.
- Bytes 0xF0, 0x0F, 0x24 (AND), with i_tx_busy held high for 10 cycles after the third byte -> o_tx_start stays 0 until i_tx_busy falls, then one pulse with o_tx_data=0x00.
- Extra byte 0x55 sent while in S_TXW -> dropped, o_overrun=1 and stays 1. The next frame 0x02, 0x01, 0x22 (SUB) still gives o_tx_data=0x01.
- i_rst driven low after the first byte 0xAA and released -> state S_A, o_alu_a=0x00, o_overrun=0. A fresh 3-byte frame completes correctly.
- With ALU_CTRL_TIMEOUT_EN and TIMEOUT=20: send 0x11, then wait 25 cycles -> back in S_A, o_busy=0. The next three bytes form a complete new frame.
- Two back-to-back frames separated only by the transmit handshake -> two o_tx_start pulses, each with the correct result, and no overrun.
